mcu_bus_bridge: RTL and testbench

MCU_BUS_BRIDGE -- requirements
Module: mcu_bus_bridge

---
 rtl/mcu_bus_pkg.sv | 24 ++
 rtl/bus_sync.sv | 26 ++
 rtl/mcu_bus_bridge.sv | 192 +++++++++++++++++++
 tb/tb_mcu_bus_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_bus_pkg.sv
// Shared types and default widths for the MCU bus bridge.
// The FSM encoding is kept as plain constants so that older tools can read it.
package mcu_bus_pkg;

  typedef logic [1:0] bus_state_t;

  localparam bus_state_t ST_IDLE   = 2'd0;
  localparam bus_state_t ST_WR_ACT = 2'd1;
  localparam bus_state_t ST_RD_ACT = 2'd2;
  localparam bus_state_t ST_COMMIT = 2'd3;

  localparam int DEF_NUM_PERIP        = 8;
  localparam int DEF_ADDR_WIDTH       = 14;
  localparam int DEF_DATA_WIDTH       = 8;
  localparam int DEF_LOCAL_ADDR_WIDTH = 8;
  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_WD_CYCLES        = 1024;

  // Chip select and one active-low strobe, both low, means that access is live.
  function automatic logic strobe_active(input logic ncs_s, input logic nstb_s);
    return ~(ncs_s | nstb_s);
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous inputs.
// Reset loads RST_VAL so that strobes can come up at their inactive level.
module bus_sync #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], d};
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/mcu_bus_bridge.sv
// Bridge from an asynchronous MCU strobe bus to single-clock peripheral channels.
// Optional bus watchdog is enabled by defining BUS_WATCHDOG_EN.
module mcu_bus_bridge
  import mcu_bus_pkg::*;
#(
  parameter int NUM_PERIP        = DEF_NUM_PERIP,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int LOCAL_ADDR_WIDTH = DEF_LOCAL_ADDR_WIDTH,
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int WD_CYCLES        = DEF_WD_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ncs,
  input  logic                            nwe,
  input  logic                            nrd,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            data_oe,
  output logic [NUM_PERIP-1:0]            perip_cs,
  output logic                            perip_we,
  output logic                            perip_rd,
  output logic [LOCAL_ADDR_WIDTH-1:0]     perip_addr,
  output logic [DATA_WIDTH-1:0]           perip_wdata,
  input  logic [NUM_PERIP*DATA_WIDTH-1:0] perip_rdata,
  output logic                            bus_err
);

  localparam int CH_W   = ADDR_WIDTH - LOCAL_ADDR_WIDTH;
  localparam int HOLD_W = $clog2(SYNC_STAGES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SYNC_STAGES);

  if (NUM_PERIP < 1 || NUM_PERIP > 16 || SYNC_STAGES < 2 || WD_CYCLES < 1 ||
      LOCAL_ADDR_WIDTH >= ADDR_WIDTH) begin : g_param_check
    $error("mcu_bus_bridge: illegal parameter combination");
  end

  logic [2:0]            strobe_s;
  logic                  s_ncs, s_nwe, s_nrd;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_data;
  logic [CH_W-1:0]       s_chan;
  logic [NUM_PERIP-1:0]  dec_cs;
  logic [NUM_PERIP-1:0]  cs_lat;
  logic [DATA_WIDTH-1:0] rd_mux;
  bus_state_t            state;
  logic                  wait_rel;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  wr_go, rd_go, idle_quiet, start_txn, in_act, wd_expire;

  // Synchronizer stage: strobes idle high, address/data idle low
  bus_sync #(.WIDTH(3), .DEPTH(SYNC_STAGES), .RST_VAL(3'b111)) u_sync_strobe (
    .clk (clk),
    .rst (rst),
    .d   ({ncs, nwe, nrd}),
    .q   (strobe_s)
  );

  bus_sync #(.WIDTH(ADDR_WIDTH + DATA_WIDTH), .DEPTH(SYNC_STAGES), .RST_VAL('0)) u_sync_data (
    .clk (clk),
    .rst (rst),
    .d   ({address, data_in}),
    .q   ({s_addr, s_data})
  );

  assign {s_ncs, s_nwe, s_nrd} = strobe_s;
  assign s_chan = s_addr[ADDR_WIDTH-1:LOCAL_ADDR_WIDTH];

  // Decode stage: out-of-range channels select nothing and read back zero
  always_comb begin
    dec_cs = '0;
    rd_mux = '0;
    for (int k = 0; k < NUM_PERIP; k++) begin
      if (int'(s_chan) == k) begin
        dec_cs[k] = 1'b1;
        rd_mux    = perip_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign wr_go      = strobe_active(s_ncs, s_nwe);
  assign rd_go      = strobe_active(s_ncs, s_nrd) & s_nwe;
  assign idle_quiet = s_ncs | (s_nwe & s_nrd);
  assign start_txn  = (state == ST_IDLE) && !wait_rel && (wr_go || rd_go);
  assign in_act     = (state == ST_WR_ACT) || (state == ST_RD_ACT);

  // Output enable follows the raw pins so read access time is not spent in the synchronizer.
  assign data_oe = ~(ncs | nrd);

  // Control stage: after reset or a timeout the bus must be seen idle before a new access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_rel    <= 1'b1;
      hold_cnt    <= HOLD_INIT;
      cs_lat      <= '0;
      perip_cs    <= '0;
      perip_we    <= 1'b0;
      perip_rd    <= 1'b0;
      perip_addr  <= '0;
      perip_wdata <= '0;
      data_out    <= '0;
    end else begin
      data_out <= rd_mux;
      perip_we <= 1'b0;
      perip_rd <= 1'b0;
      perip_cs <= '0;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);

      case (state)
        ST_IDLE: begin
          if (wait_rel) begin
            if (hold_cnt == '0 && idle_quiet) wait_rel <= 1'b0;
          end else if (wr_go) begin
            state       <= ST_WR_ACT;
            perip_addr  <= s_addr[LOCAL_ADDR_WIDTH-1:0];
            perip_wdata <= s_data;
            cs_lat      <= dec_cs;
          end else if (rd_go) begin
            state      <= ST_RD_ACT;
            perip_addr <= s_addr[LOCAL_ADDR_WIDTH-1:0];
            perip_rd   <= 1'b1;
            perip_cs   <= dec_cs;
          end
        end
        ST_WR_ACT: begin
          // Only samples taken while the strobes are still low are trusted.
          if (wr_go) begin
            perip_addr  <= s_addr[LOCAL_ADDR_WIDTH-1:0];
            perip_wdata <= s_data;
            cs_lat      <= dec_cs;
          end else begin
            state    <= ST_COMMIT;
            perip_we <= 1'b1;
            perip_cs <= cs_lat;
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        ST_RD_ACT: begin
          if (s_ncs | s_nrd) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (wd_expire) begin
        state    <= ST_IDLE;
        wait_rel <= 1'b1;
        perip_we <= 1'b0;
        perip_rd <= 1'b0;
        perip_cs <= '0;
      end
    end
  end

`ifdef BUS_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_err_q;

  // The entry cycle counts as the first cycle of the access.
  assign wd_expire = in_act && (wd_cnt >= WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else begin
      if (wd_expire) begin
        wd_cnt   <= '0;
        wd_err_q <= 1'b1;
      end else if (in_act) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else if (start_txn) begin
        wd_cnt <= WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  assign bus_err = wd_err_q;
`else
  logic unused_act;
  assign unused_act = in_act & start_txn;
  assign wd_expire  = 1'b0;
  assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_bus_bridge.sv
// Table-driven bench for mcu_bus_bridge with a pulse scoreboard.
// Watchdog expectations switch on BUS_WATCHDOG_EN.
module tb_mcu_bus_bridge;

  localparam int NP  = 4;
  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int LAW = 8;
  localparam int SS  = 2;
  localparam int WD  = 16;

  typedef struct {
    logic           is_wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    int             hold;
    logic [NP-1:0]  exp_cs;
    logic [LAW-1:0] exp_addr;
    logic [DW-1:0]  exp_data;
    logic           oor;
  } vec_t;

  typedef struct {
    logic           we;
    logic           rd;
    logic [NP-1:0]  cs;
    logic [LAW-1:0] addr;
    logic [DW-1:0]  wdata;
    int             cyc;
  } obs_t;

  typedef struct {
    logic           we;
    logic [NP-1:0]  cs;
    logic [LAW-1:0] addr;
    logic [DW-1:0]  wdata;
    int             cyc;
    logic           opt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              ncs, nwe, nrd;
  logic [AW-1:0]     address;
  logic [DW-1:0]     data_in;
  logic [DW-1:0]     data_out;
  logic              data_oe;
  logic [NP-1:0]     perip_cs;
  logic              perip_we, perip_rd;
  logic [LAW-1:0]    perip_addr;
  logic [DW-1:0]     perip_wdata;
  logic [NP*DW-1:0]  perip_rdata;
  logic              bus_err;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  obs_t obs_mem [256];
  int   obs_wr = 0;
  int   obs_rd = 0;
  exp_t exp_q [$];
  vec_t vecs [9];

  mcu_bus_bridge #(
    .NUM_PERIP(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .LOCAL_ADDR_WIDTH(LAW), .SYNC_STAGES(SS), .WD_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .ncs(ncs), .nwe(nwe), .nrd(nrd),
    .address(address), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .perip_cs(perip_cs), .perip_we(perip_we), .perip_rd(perip_rd),
    .perip_addr(perip_addr), .perip_wdata(perip_wdata),
    .perip_rdata(perip_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle with a pulse or a live chip select.
  always @(negedge clk) begin
    if (!rst && (perip_we || perip_rd || perip_cs != '0) && obs_wr < 256) begin
      obs_mem[obs_wr] <= '{perip_we, perip_rd, perip_cs, perip_addr, perip_wdata, cyc};
      obs_wr <= obs_wr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_window();
    exp_t e;
    obs_t o;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.opt) begin
        while (obs_rd < obs_wr) begin
          o = obs_mem[obs_rd];
          obs_rd++;
          check("oor_cs_zero", 32'(o.cs), 0);
        end
      end else begin
        check("pulse_seen", 32'(obs_rd < obs_wr), 1);
        if (obs_rd < obs_wr) begin
          o = obs_mem[obs_rd];
          obs_rd++;
          check("pulse_we", 32'(o.we), 32'(e.we));
          check("pulse_rd", 32'(o.rd), 32'(!e.we));
          check("pulse_cs", 32'(o.cs), 32'(e.cs));
          check("pulse_addr", 32'(o.addr), 32'(e.addr));
          if (e.we) check("pulse_wdata", 32'(o.wdata), 32'(e.wdata));
          check("pulse_cycle", 32'(o.cyc), 32'(e.cyc));
        end
      end
    end
    check("extra_pulses", 32'(obs_wr - obs_rd), 0);
    obs_rd = obs_wr;
  endtask

  task automatic push_exp(input logic we, input logic [NP-1:0] cs, input logic [LAW-1:0] a,
                          input logic [DW-1:0] d, input int c, input logic opt);
    exp_t e;
    e.we = we; e.cs = cs; e.addr = a; e.wdata = d; e.cyc = c; e.opt = opt;
    exp_q.push_back(e);
  endtask

  task automatic release_bus();
    ncs = 1'b1; nwe = 1'b1; nrd = 1'b1;
    address = 14'h3FFF;
    data_in = 8'h00;
  endtask

  task automatic run_vec(input vec_t v);
    int drv, rel;
    address = v.addr;
    data_in = v.wdata;
    ncs = 1'b0;
    if (v.is_wr) nwe = 1'b0; else nrd = 1'b0;
    drv = cyc;
    #1 check(v.is_wr ? "oe_during_write" : "oe_during_read", 32'(data_oe), 32'(!v.is_wr));
    repeat (v.hold) @(negedge clk);
    if (!v.is_wr) check("read_data_out", 32'(data_out), 32'(v.exp_data));
    release_bus();
    rel = cyc;
    #1 check("oe_after_release", 32'(data_oe), 0);
    push_exp(v.is_wr, v.exp_cs, v.exp_addr, v.exp_data,
             v.is_wr ? rel + SS + 1 : drv + SS + 1, v.oor);
    repeat (6) @(negedge clk);
    check_window();
    if (v.is_wr && !v.oor) begin
      check("addr_held", 32'(perip_addr), 32'(v.exp_addr));
      check("wdata_held", 32'(perip_wdata), 32'(v.exp_data));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"}, 32'(perip_cs), 0);
    check({tag, "_we"}, 32'(perip_we), 0);
    check({tag, "_rd"}, 32'(perip_rd), 0);
    check({tag, "_addr"}, 32'(perip_addr), 0);
    check({tag, "_wdata"}, 32'(perip_wdata), 0);
    check({tag, "_data_out"}, 32'(data_out), 0);
    check({tag, "_bus_err"}, 32'(bus_err), 0);
  endtask

  initial begin
    int drv, rel;
    // channel 0..3 read data: 0x0F, 0xB1, 0x5A, 0xD3
    perip_rdata = {8'hD3, 8'h5A, 8'hB1, 8'h0F};
    //           is_wr addr      wdata  hold cs       addr   data   oor
    vecs[0] = '{1'b1, 14'h0105, 8'hA5, 10, 4'b0010, 8'h05, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 14'h0210, 8'h00,  8, 4'b0100, 8'h10, 8'h5A, 1'b0};
    vecs[2] = '{1'b1, 14'h0000, 8'h3C,  1, 4'b0001, 8'h00, 8'h3C, 1'b0};
    vecs[3] = '{1'b1, 14'h03FF, 8'hFF,  4, 4'b1000, 8'hFF, 8'hFF, 1'b0};
    vecs[4] = '{1'b0, 14'h0001, 8'h00,  6, 4'b0001, 8'h01, 8'h0F, 1'b0};
    vecs[5] = '{1'b0, 14'h03C3, 8'h00,  6, 4'b1000, 8'hC3, 8'hD3, 1'b0};
    vecs[6] = '{1'b1, 14'h0700, 8'h77,  5, 4'b0000, 8'h00, 8'h77, 1'b1};
    vecs[7] = '{1'b0, 14'h0700, 8'h00,  6, 4'b0000, 8'h00, 8'h00, 1'b1};
    vecs[8] = '{1'b1, 14'h3FFF, 8'h11,  3, 4'b0000, 8'hFF, 8'h11, 1'b1};

    rst = 1'b1;
    release_bus();
    address = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-to-back writes: one pulse per low period
    address = 14'h0101; data_in = 8'h12; ncs = 1'b0; nwe = 1'b0;
    repeat (3) @(negedge clk);
    release_bus();
    rel = cyc;
    push_exp(1'b1, 4'b0010, 8'h01, 8'h12, rel + SS + 1, 1'b0);
    repeat (2) @(negedge clk);
    address = 14'h0202; data_in = 8'h34; ncs = 1'b0; nwe = 1'b0;
    repeat (3) @(negedge clk);
    release_bus();
    rel = cyc;
    push_exp(1'b1, 4'b0100, 8'h02, 8'h34, rel + SS + 1, 1'b0);
    repeat (8) @(negedge clk);
    check_window();

    // Reset in the middle of a write aborts it
    address = 14'h0102; data_in = 8'h99; ncs = 1'b0; nwe = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    release_bus();
    repeat (8) @(negedge clk);
    check_window();
    check("midreset_addr_after", 32'(perip_addr), 0);
    check("midreset_wdata_after", 32'(perip_wdata), 0);

    // Recovery with a fresh full write
    address = 14'h0203; data_in = 8'h44; ncs = 1'b0; nwe = 1'b0;
    repeat (5) @(negedge clk);
    release_bus();
    rel = cyc;
    push_exp(1'b1, 4'b0100, 8'h03, 8'h44, rel + SS + 1, 1'b0);
    repeat (6) @(negedge clk);
    check_window();

    // Long write: watchdog limit reached at WD + SS cycles when enabled
    address = 14'h0101; data_in = 8'h5C; ncs = 1'b0; nwe = 1'b0;
    drv = cyc;
    repeat (WD + SS - 1) @(negedge clk);
    check("wd_err_before_limit", 32'(bus_err), 0);
    @(negedge clk);
`ifdef BUS_WATCHDOG_EN
    check("wd_err_at_limit", 32'(bus_err), 1);
`else
    check("no_wd_err_at_limit", 32'(bus_err), 0);
`endif
    repeat (40 - (cyc - drv)) @(negedge clk);
    release_bus();
    rel = cyc;
`ifndef BUS_WATCHDOG_EN
    push_exp(1'b1, 4'b0010, 8'h01, 8'h5C, rel + SS + 1, 1'b0);
`endif
    repeat (8) @(negedge clk);
    check_window();
`ifdef BUS_WATCHDOG_EN
    check("wd_err_sticky", 32'(bus_err), 1);
    #2 rst = 1'b1;
    #1 check("wd_err_cleared", 32'(bus_err), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
`else
    check("no_wd_err_after", 32'(bus_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
